// File: rtl/mnist_pkg.sv
// Shared MNIST pipeline types: signed score type and class index sizing.
package mnist_pkg;

    localparam int FEATURE_W   = 16;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);

    typedef logic signed [FEATURE_W-1:0] feature_type;
    typedef logic [CLASS_W-1:0]          class_idx_type;

endpackage

// File: rtl/feature_if.sv
// Valid/ready feature stream between pipeline layers; ready flows back from the sink.
interface feature_if
    import mnist_pkg::*;
#(
    parameter int N = 1
);
    logic        valid;
    logic        ready;
    feature_type features [N];

    modport source (output valid, output features, input ready);
    modport sink   (input valid, input features, output ready);
endinterface

// File: rtl/argmax_update.sv
// One compare step of a running argmax; beat 0 seeds the running max unconditionally.
module argmax_update
    import mnist_pkg::*;
#(
    parameter int CLASS_W = mnist_pkg::CLASS_W
) (
    input  feature_type        cur_max,
    input  logic [CLASS_W-1:0] cur_idx,
    input  feature_type        score,
    input  logic [CLASS_W-1:0] idx,
    input  logic               first,
    output feature_type        nxt_max,
    output logic [CLASS_W-1:0] nxt_idx
);

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        nxt_max = cur_max;
        nxt_idx = cur_idx;
        if (first || (score > cur_max)) begin
            nxt_max = score;
            nxt_idx = idx;
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Final MNIST stage: picks the highest signed score of each vector and offers it,
// with a running image count, on a valid/ready result port.
module argmax_classifier
    import mnist_pkg::feature_type;
#(
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
    parameter int CLASS_W     = $clog2(NUM_CLASSES),
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    feature_if.sink            features_in,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [CLASS_W-1:0] result_class,
    output feature_type        result_score,
    output logic [COUNT_W-1:0] image_count
);

    typedef enum logic {S_RECV, S_OUT} state_type;

    state_type          state;
    state_type          state_nxt;
    logic               recv_ready;
    logic [CLASS_W-1:0] beat_idx;
    feature_type        max_reg;
    logic [CLASS_W-1:0] argmax_reg;
    feature_type        nxt_max;
    logic [CLASS_W-1:0] nxt_idx;
    logic               beat_fire;
    logic               last_beat;
    logic               result_fire;

    assign last_beat   = (beat_idx == CLASS_W'(NUM_CLASSES - 1));
    assign beat_fire   = features_in.valid && features_in.ready;
    assign result_fire = result_valid && result_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RECV:  if (beat_fire && last_beat) state_nxt = S_OUT;
            S_OUT:   if (result_fire)            state_nxt = S_RECV;
            default: state_nxt = S_RECV;
        endcase
    end

    always_comb begin
        recv_ready   = (state == S_RECV);
        result_valid = (state == S_OUT);
    end

    // Ready is held low while reset is asserted even though the state already reads S_RECV.
    assign features_in.ready = recv_ready && !reset;

    argmax_update #(
        .CLASS_W (CLASS_W)
    ) u_update (
        .cur_max (max_reg),
        .cur_idx (argmax_reg),
        .score   (features_in.features[0]),
        .idx     (beat_idx),
        .first   (beat_idx == '0),
        .nxt_max (nxt_max),
        .nxt_idx (nxt_idx)
    );

    // Running max only moves on accepted beats, so it stays frozen while S_OUT is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_idx   <= '0;
            max_reg    <= '0;
            argmax_reg <= '0;
        end else if (beat_fire) begin
            beat_idx   <= last_beat ? '0 : beat_idx + CLASS_W'(1);
            max_reg    <= nxt_max;
            argmax_reg <= nxt_idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            image_count <= '0;
        end else if (result_fire) begin
            image_count <= image_count + COUNT_W'(1);
        end
    end

    assign result_class = argmax_reg;
    assign result_score = max_reg;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: table of score vectors plus stall, reset and wrap sequences.
module tb_argmax_classifier;
    import mnist_pkg::*;

    localparam int N      = NUM_CLASSES;
    localparam int CNT_W  = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic               clock = 1'b0;
    logic               reset;
    logic               result_valid;
    logic               result_ready;
    logic [CLASS_W-1:0] result_class;
    feature_type        result_score;
    logic [CNT_W-1:0]   image_count;

    feature_if #(.N(1)) feat ();

    always #5 clock = ~clock;

    argmax_classifier #(
        .NUM_CLASSES (N),
        .CLASS_W     (CLASS_W),
        .COUNT_W     (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .features_in  (feat),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score),
        .image_count  (image_count)
    );

    typedef struct {
        int scores [N];
        int exp_class;
        int exp_score;
        int max_gap;
    } vec_type;

    vec_type vecs [5];
    int      cur_scores [N];
    int      errors    = 0;
    int      checks    = 0;
    int      exp_count = 0;

    task automatic checkOutput(input string name, input integer actual, input integer expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic sendBeat(input int score, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            feat.valid = 1'b0;
        end
        @(negedge clock);
        feat.valid       = 1'b1;
        feat.features[0] = feature_type'(score);
        n = 0;
        while (!feat.ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!feat.ready) checkOutput("beat_ready_timeout", integer'(feat.ready), 1);
        @(posedge clock);
    endtask

    task automatic applyStimulus(input int max_gap);
        for (int k = 0; k < N; k++) begin
            sendBeat(cur_scores[k], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
            if (k == N - 2) checkOutput("valid_before_last", integer'(result_valid), 0);
        end
        @(negedge clock);
        feat.valid = 1'b0;
        checkOutput("valid_after_last", integer'(result_valid), 1);
    endtask

    task automatic acceptResult(input string name, input int exp_class, input int exp_score);
        checkOutput({name, "_class"}, integer'(result_class), exp_class);
        checkOutput({name, "_score"}, integer'(result_score), exp_score);
        result_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        result_ready = 1'b0;
        exp_count    = (exp_count + 1) % CNT_MOD;
        checkOutput({name, "_count"}, integer'(image_count), exp_count);
        checkOutput({name, "_valid_drop"}, integer'(result_valid), 0);
        checkOutput({name, "_ready_back"}, integer'(feat.ready), 1);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        feat.valid = 1'b0;
        reset      = 1'b1;
        #1;
        checkOutput("rst_ready", integer'(feat.ready), 0);
        checkOutput("rst_valid", integer'(result_valid), 0);
        checkOutput("rst_class", integer'(result_class), 0);
        checkOutput("rst_score", integer'(result_score), 0);
        checkOutput("rst_count", integer'(image_count), 0);
        exp_count = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int best;
        vecs[0] = '{scores: '{1, 5, 3, 9, 2, 0, -4, 7, 8, 6},
                    exp_class: 3, exp_score: 9, max_gap: 0};
        vecs[1] = '{scores: '{-20, -19, -18, -17, -16, -15, -14, -13, -12, -11},
                    exp_class: 9, exp_score: -11, max_gap: 0};
        vecs[2] = '{scores: '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4},
                    exp_class: 0, exp_score: 4, max_gap: 0};
        vecs[3] = '{scores: '{9, 1, 2, 3, 4, 5, 6, 7, 8, 9},
                    exp_class: 0, exp_score: 9, max_gap: 0};
        vecs[4] = '{scores: '{9, 1, 2, 3, 4, 5, 6, 7, 8, 9},
                    exp_class: 0, exp_score: 9, max_gap: 5};

        reset            = 1'b1;
        result_ready     = 1'b0;
        feat.valid       = 1'b0;
        feat.features[0] = '0;
        #1;
        checkOutput("init_ready", integer'(feat.ready), 0);
        checkOutput("init_valid", integer'(result_valid), 0);
        checkOutput("init_class", integer'(result_class), 0);
        checkOutput("init_score", integer'(result_score), 0);
        checkOutput("init_count", integer'(image_count), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_ready", integer'(feat.ready), 1);

        for (int i = 0; i < 5; i++) begin
            cur_scores = vecs[i].scores;
            applyStimulus(vecs[i].max_gap);
            acceptResult($sformatf("vec%0d", i), vecs[i].exp_class, vecs[i].exp_score);
        end

        // Stall the result port with upstream still offering data.
        cur_scores = vecs[0].scores;
        applyStimulus(0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            feat.valid       = 1'b1;
            feat.features[0] = feature_type'(77);
            checkOutput("stall_class", integer'(result_class), 3);
            checkOutput("stall_score", integer'(result_score), 9);
            checkOutput("stall_ready", integer'(feat.ready), 0);
        end
        checkOutput("stall_count", integer'(image_count), exp_count);
        feat.valid = 1'b0;
        acceptResult("stall", 3, 9);
        cur_scores = vecs[1].scores;
        applyStimulus(0);
        acceptResult("after_stall", 9, -11);

        // Partial vector cut off by reset must not leak into the next one.
        for (int k = 0; k < 6; k++) sendBeat(100, 0);
        pulseReset();
        cur_scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        applyStimulus(0);
        acceptResult("post_reset", 9, 1);

        // Counter wrap with random vectors checked against a reference argmax.
        pulseReset();
        for (int img = 0; img < CNT_MOD + 3; img++) begin
            for (int k = 0; k < N; k++) cur_scores[k] = int'($urandom_range(200, 0)) - 100;
            best = 0;
            for (int k = 1; k < N; k++) if (cur_scores[k] > cur_scores[best]) best = k;
            applyStimulus(2);
            acceptResult($sformatf("rand%0d", img), best, cur_scores[best]);
        end
        checkOutput("count_wrap", integer'(image_count), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
